// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: two read ports, one byte-enabled write port,
// and the bulk-clear handshake.
interface regfile_param_if #(
   parameter int WIDTH     = 32,
   parameter int ADDR_BITS = 5
);
   logic [ADDR_BITS-1:0] ReadRegister1;
   logic [ADDR_BITS-1:0] ReadRegister2;
   logic [WIDTH-1:0]     ReadData1;
   logic [WIDTH-1:0]     ReadData2;
   logic [ADDR_BITS-1:0] WriteRegister;
   logic [WIDTH-1:0]     WriteData;
   logic [WIDTH/8-1:0]   ByteEn;
   logic                 RegWrite;
   logic                 ClearReq;
   logic                 Busy;
   logic                 ClearDone;
   logic                 WriteDropped;

   modport master (
      output ReadRegister1, ReadRegister2, WriteRegister, WriteData, ByteEn,
             RegWrite, ClearReq,
      input  ReadData1, ReadData2, Busy, ClearDone, WriteDropped
   );

   modport slave (
      input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, ByteEn,
             RegWrite, ClearReq,
      output ReadData1, ReadData2, Busy, ClearDone, WriteDropped
   );
endinterface

// File: rtl/regfile_param.sv
// Parametrised 2R/1W register file with byte-enable writes and a sequential bulk-clear engine.
// Optional write-to-read forwarding is enabled by defining REGFILE_WRITE_BYPASS_EN.
module regfile_param #(
   parameter int WIDTH     = 32,
   parameter int ADDR_BITS = 5,
   parameter int ZERO_REG  = 1
) (
   input logic               Clk,
   input logic               Reset_n,
   regfile_param_if.slave    bus
);
   localparam int DEPTH  = 1 << ADDR_BITS;
   localparam int NBYTES = WIDTH / 8;
   localparam bit ZERO_EN = (ZERO_REG != 0);
   localparam logic [ADDR_BITS-1:0] ADDR_ZERO = {ADDR_BITS{1'b0}};
   localparam logic [ADDR_BITS-1:0] LAST_PTR  = ADDR_BITS'(DEPTH - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   logic [WIDTH-1:0]     mem_r [DEPTH];
   state_t               state_r;
   logic [ADDR_BITS-1:0] clear_ptr_r;
   logic                 busy_r;
   logic                 clear_done_r;
   logic                 write_dropped_r;

   logic                 wr_zero_s;
   logic                 wr_accept_s;
   logic [WIDTH-1:0]     wr_merged_s;
   logic                 rd1_zero_s;
   logic                 rd2_zero_s;
   logic                 fwd1_s;
   logic                 fwd2_s;
   logic [WIDTH-1:0]     rd1_s;
   logic [WIDTH-1:0]     rd2_s;

   function automatic logic [WIDTH-1:0] merge_bytes(
      input logic [WIDTH-1:0]  old_v,
      input logic [WIDTH-1:0]  new_v,
      input logic [NBYTES-1:0] be
   );
      logic [WIDTH-1:0] res;
      res = old_v;
      for (int i = 0; i < NBYTES; i++) begin
         if (be[i]) begin
            res[8*i +: 8] = new_v[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_v[8*i +: 8];
         end
      end
      return res;
   endfunction

   // Write acceptance and merged write value; entry 0 writes vanish when hardwired.
   always_comb begin
      wr_zero_s   = ZERO_EN && (bus.WriteRegister == ADDR_ZERO);
      wr_accept_s = bus.RegWrite && !busy_r && !wr_zero_s;
      wr_merged_s = merge_bytes(mem_r[bus.WriteRegister], bus.WriteData, bus.ByteEn);
   end

   // Read ports: hardwired zero first, then optional forwarding, then storage.
   always_comb begin
      rd1_zero_s = ZERO_EN && (bus.ReadRegister1 == ADDR_ZERO);
      rd2_zero_s = ZERO_EN && (bus.ReadRegister2 == ADDR_ZERO);
`ifdef REGFILE_WRITE_BYPASS_EN
      fwd1_s = wr_accept_s && (bus.ReadRegister1 == bus.WriteRegister);
      fwd2_s = wr_accept_s && (bus.ReadRegister2 == bus.WriteRegister);
`else
      fwd1_s = 1'b0;
      fwd2_s = 1'b0;
`endif
      if (rd1_zero_s) begin
         rd1_s = {WIDTH{1'b0}};
      end else if (fwd1_s) begin
         rd1_s = wr_merged_s;
      end else begin
         rd1_s = mem_r[bus.ReadRegister1];
      end
      if (rd2_zero_s) begin
         rd2_s = {WIDTH{1'b0}};
      end else if (fwd2_s) begin
         rd2_s = wr_merged_s;
      end else begin
         rd2_s = mem_r[bus.ReadRegister2];
      end
   end

   assign bus.ReadData1    = rd1_s;
   assign bus.ReadData2    = rd2_s;
   assign bus.Busy         = busy_r;
   assign bus.ClearDone    = clear_done_r;
   assign bus.WriteDropped = write_dropped_r;

   // Storage, clear FSM and handshake flags; the clear write follows the
   // normal write so a write in the request cycle is later wiped by the sweep.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
         state_r         <= IDLE;
         clear_ptr_r     <= ADDR_ZERO;
         busy_r          <= 1'b0;
         clear_done_r    <= 1'b0;
         write_dropped_r <= 1'b0;
      end else begin
         clear_done_r    <= 1'b0;
         write_dropped_r <= bus.RegWrite && busy_r;
         if (wr_accept_s) begin
            mem_r[bus.WriteRegister] <= wr_merged_s;
         end
         case (state_r)
            IDLE: begin
               if (bus.ClearReq) begin
                  state_r     <= CLEAR;
                  busy_r      <= 1'b1;
                  clear_ptr_r <= ADDR_ZERO;
               end else begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            end
            CLEAR: begin
               mem_r[clear_ptr_r] <= {WIDTH{1'b0}};
               if (clear_ptr_r == LAST_PTR) begin
                  state_r      <= IDLE;
                  busy_r       <= 1'b0;
                  clear_done_r <= 1'b1;
               end else begin
                  clear_ptr_r <= clear_ptr_r + ADDR_BITS'(1);
                  busy_r      <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: expected read values are queued when
// stimulus is applied and popped when the read ports are sampled.
module tb_regfile_param;
   localparam int W  = 32;
   localparam int AB = 5;

   logic Clk = 1'b0;
   logic Reset_n;
   always #5 Clk = ~Clk;

   regfile_param_if #(.WIDTH(W), .ADDR_BITS(AB)) ifc ();
   regfile_param #(.WIDTH(W), .ADDR_BITS(AB), .ZERO_REG(1)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (ifc)
   );

   int n_cmp = 0;
   int n_mis = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_val(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic compare(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      e = 32'hxxxx_xxxx;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check(tag, obs, e);
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      ifc.RegWrite      = 1'b1;
      ifc.WriteRegister = a;
      ifc.WriteData     = d;
      ifc.ByteEn        = be;
      step();
      ifc.RegWrite = 1'b0;
      ifc.ByteEn   = 4'h0;
   endtask

   task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
      ifc.ReadRegister1 = a1;
      ifc.ReadRegister2 = a2;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cnt;
      Reset_n           = 1'b0;
      ifc.ReadRegister1 = 5'd0;
      ifc.ReadRegister2 = 5'd0;
      ifc.WriteRegister = 5'd0;
      ifc.WriteData     = 32'h0;
      ifc.ByteEn        = 4'h0;
      ifc.RegWrite      = 1'b0;
      ifc.ClearReq      = 1'b0;
      repeat (3) @(posedge Clk);
      #1;

      // reset state
      rd(5'd2, 5'd31);
      check("rst_busy", 32'(ifc.Busy), 32'd0);
      check("rst_done", 32'(ifc.ClearDone), 32'd0);
      check("rst_drop", 32'(ifc.WriteDropped), 32'd0);
      expect_val(32'd0); compare("rst_rd1", ifc.ReadData1);
      Reset_n = 1'b1;
      step();

      // basic write, both ports same address
      expect_val(32'd42); expect_val(32'd42);
      wr(5'd2, 32'h0000_002A, 4'hF);
      rd(5'd2, 5'd2);
      compare("t1_rd1", ifc.ReadData1);
      compare("t1_rd2", ifc.ReadData2);

      // RegWrite low commits nothing
      ifc.WriteData = 32'd1; ifc.WriteRegister = 5'd2;
      step();
      expect_val(32'd42); rd(5'd2, 5'd2); compare("t2_nowr", ifc.ReadData1);
      expect_val(32'd1); expect_val(32'd0);
      wr(5'd2, 32'd1, 4'hF);
      rd(5'd2, 5'd3);
      compare("t2_rd1", ifc.ReadData1);
      compare("t2_rd2", ifc.ReadData2);

      // hardwired zero and byte enables
      wr(5'd0, 32'hDEAD_BEEF, 4'hF);
      check("t3_zero_nodrop", 32'(ifc.WriteDropped), 32'd0);
      expect_val(32'd0); rd(5'd0, 5'd0); compare("t3_r0", ifc.ReadData1);
      wr(5'd5, 32'h0, 4'hF);
      expect_val(32'h00FF_00FF);
      wr(5'd5, 32'hFFFF_FFFF, 4'b0101);
      rd(5'd5, 5'd5); compare("t3_be0101", ifc.ReadData1);
      expect_val(32'h00FF_00FF);
      wr(5'd5, 32'hFFFF_FFFF, 4'b0000);
      check("t3_be0_nodrop", 32'(ifc.WriteDropped), 32'd0);
      rd(5'd5, 5'd5); compare("t3_be0", ifc.ReadData1);
      expect_val(32'hAAFF_00FF);
      wr(5'd5, 32'hAABB_CCDD, 4'b1000);
      rd(5'd5, 5'd5); compare("t3_be1000", ifc.ReadData2);

      // forwarding before the write edge
      ifc.RegWrite = 1'b1; ifc.WriteRegister = 5'd9;
      ifc.WriteData = 32'h1234_5678; ifc.ByteEn = 4'hF;
`ifdef REGFILE_WRITE_BYPASS_EN
      expect_val(32'h1234_5678);
`else
      expect_val(32'h0);
`endif
      rd(5'd9, 5'd0); compare("t6_pre_edge", ifc.ReadData1);
      step();
      ifc.RegWrite = 1'b0;
      expect_val(32'h1234_5678); rd(5'd9, 5'd9); compare("t6_post_edge", ifc.ReadData1);
      ifc.RegWrite = 1'b1; ifc.WriteRegister = 5'd0; ifc.WriteData = 32'hFFFF_FFFF;
      expect_val(32'h0); rd(5'd0, 5'd0); compare("t6_r0_nobyp", ifc.ReadData1);
      step();
      ifc.RegWrite = 1'b0;

      // fill, clear sweep with live reads
      for (int i = 1; i < 32; i++) wr(5'(i), 32'(i), 4'hF);
      ifc.ClearReq = 1'b1;
      step();
      ifc.ClearReq = 1'b0;
      for (int k = 0; k < 32; k++) begin
         rd(5'd31, 5'(k));
         check("t4_busy", 32'(ifc.Busy), 32'd1);
         check("t4_nodone", 32'(ifc.ClearDone), 32'd0);
         expect_val(32'd31); compare("t4_r31_live", ifc.ReadData1);
         expect_val(32'(k)); compare("t4_ptr_entry", ifc.ReadData2);
         if (k > 0) begin
            rd(5'd31, 5'(k - 1));
            expect_val(32'd0); compare("t4_below_ptr", ifc.ReadData2);
         end
         step();
      end
      check("t4_busy_fall", 32'(ifc.Busy), 32'd0);
      check("t4_done", 32'(ifc.ClearDone), 32'd1);
      step();
      check("t4_done_pulse", 32'(ifc.ClearDone), 32'd0);
      for (int a = 0; a < 32; a++) begin
         expect_val(32'd0); rd(5'(a), 5'(a)); compare("t4_all_zero", ifc.ReadData1);
      end

      // write in request cycle commits; writes during clear are dropped
      wr(5'd7, 32'd77, 4'hF);
      ifc.RegWrite = 1'b1; ifc.WriteRegister = 5'd10;
      ifc.WriteData = 32'hA5; ifc.ByteEn = 4'hF; ifc.ClearReq = 1'b1;
      step();
      ifc.RegWrite = 1'b0; ifc.ClearReq = 1'b0;
      check("t5_drop_first", 32'(ifc.WriteDropped), 32'd0);
      expect_val(32'hA5); rd(5'd10, 5'd7); compare("t5_req_cycle_wr", ifc.ReadData1);
      expect_val(32'd77); compare("t5_r7_live", ifc.ReadData2);
      repeat (10) step();
      ifc.RegWrite = 1'b1; ifc.WriteRegister = 5'd3;
      ifc.WriteData = 32'd33; ifc.ByteEn = 4'hF; ifc.ClearReq = 1'b1;
      step();
      ifc.RegWrite = 1'b0; ifc.ClearReq = 1'b0;
      check("t5_dropped", 32'(ifc.WriteDropped), 32'd1);
      step();
      check("t5_drop_pulse", 32'(ifc.WriteDropped), 32'd0);
      cnt = 0;
      while (ifc.Busy && cnt < 40) begin step(); cnt++; end
      check("t5_no_restart", 32'(cnt), 32'd20);
      expect_val(32'd0); expect_val(32'd0);
      rd(5'd3, 5'd7);
      compare("t5_r3", ifc.ReadData1);
      compare("t5_r7", ifc.ReadData2);
      expect_val(32'd66);
      wr(5'd6, 32'd66, 4'hF);
      rd(5'd6, 5'd6); compare("t5_retry", ifc.ReadData1);

      // reset in the middle of a clear
      wr(5'd20, 32'd44, 4'hF);
      ifc.ClearReq = 1'b1;
      step();
      ifc.ClearReq = 1'b0;
      repeat (10) step();
      Reset_n = 1'b0;
      #1;
      check("t5_rst_busy", 32'(ifc.Busy), 32'd0);
      expect_val(32'd0); rd(5'd20, 5'd6); compare("t5_rst_r20", ifc.ReadData1);
      expect_val(32'd0); compare("t5_rst_r6", ifc.ReadData2);
      #2;
      Reset_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (ifc.ClearDone) cnt++;
      end
      check("t5_rst_nodone", 32'(cnt), 32'd0);

      // held request: done pulse followed by a new sweep
      ifc.ClearReq = 1'b1;
      step();
      repeat (31) step();
      check("bb_busy_last", 32'(ifc.Busy), 32'd1);
      step();
      check("bb_done", 32'(ifc.ClearDone), 32'd1);
      check("bb_busy_gap", 32'(ifc.Busy), 32'd0);
      step();
      ifc.ClearReq = 1'b0;
      check("bb_restart", 32'(ifc.Busy), 32'd1);
      check("bb_done_low", 32'(ifc.ClearDone), 32'd0);
      cnt = 0;
      while (ifc.Busy && cnt < 40) begin step(); cnt++; end
      check("bb_len", 32'(cnt), 32'd32);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
